// File: rtl/convb_load_sequencer_pkg.sv
// Shared types and default depths for the conv-B load sequencer.
// Imported by the sequencer top and its bank writer.
package convb_load_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WM,
        LOAD_BM,
        LOAD_IFM,
        START,
        WAIT_END,
        DONE
    } state_e;

    localparam int WM_DEPTH_C  = 900;
    localparam int BM_DEPTH_C  = 6;
    localparam int IFM_WORDS_C = 196;

    function automatic int cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/convb_load_sequencer_if.sv
// Streamed-word valid/ready channel from the RISC-V side.
// master drives words, slave (the sequencer) returns ready.
interface convb_load_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/convb_bank_writer.sv
// Address counter, bank one-hot and registered write port.
// sel picks depth B and routes the enable to wr_en_b.
module convb_bank_writer
    import convb_load_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BANKS      = 3,
    parameter int DEPTH_A    = WM_DEPTH_C,
    parameter int DEPTH_B    = BM_DEPTH_C,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic                  sel,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  last,
    output logic [BANKS-1:0]      wr_en_a,
    output logic [BANKS-1:0]      wr_en_b,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int DMAX = (DEPTH_A > DEPTH_B) ? DEPTH_A : DEPTH_B;
    localparam int CW   = cnt_w(DMAX);

    localparam logic [CW-1:0]    TOP_A    = CW'(DEPTH_A - 1);
    localparam logic [CW-1:0]    TOP_B    = CW'(DEPTH_B - 1);
    localparam logic [BANKS-1:0] OH_FIRST = BANKS'(1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BANKS-1:0]      oh_q, oh_d;
    logic [BANKS-1:0]      en_a_q, en_a_d;
    logic [BANKS-1:0]      en_b_q, en_b_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  cnt_top;

    always_comb begin
        cnt_top = (cnt_q == (sel ? TOP_B : TOP_A));
        last    = accept && cnt_top && oh_q[BANKS-1];
        cnt_d   = cnt_q;
        oh_d    = oh_q;
        en_a_d  = '0;
        en_b_d  = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (clear) begin
            cnt_d = '0;
            oh_d  = OH_FIRST;
        end else if (accept) begin
            en_a_d = sel ? '0 : oh_q;
            en_b_d = sel ? oh_q : '0;
            addr_d = ADDR_WIDTH'(cnt_q);
            data_d = wdata;
            // wrapping past the last bank re-arms bank 0 for the next phase
            if (cnt_top) begin
                cnt_d = '0;
                oh_d  = oh_q[BANKS-1] ? OH_FIRST : (oh_q << 1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            oh_q   <= '0;
            en_a_q <= '0;
            en_b_q <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            oh_q   <= oh_d;
            en_a_q <= en_a_d;
            en_b_q <= en_b_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign wr_en_a = en_a_q;
    assign wr_en_b = en_b_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;

endmodule

// File: rtl/convb_load_sequencer.sv
// Streams weights, biases and IFM into conv layer B,
// then starts the layer and waits for its end handshake.
module convb_load_sequencer
    import convb_load_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int WM_BANKS       = 3,
    parameter int WM_DEPTH       = WM_DEPTH_C,
    parameter int BM_DEPTH       = BM_DEPTH_C,
    parameter int IFM_WORDS      = IFM_WORDS_C,
    parameter int ADDR_WIDTH     = 15,
    parameter int IFM_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_go,
    input  logic                      cfg_skip_weights,
    convb_load_sequencer_if.slave     in_if,
    output logic [DATA_WIDTH-1:0]     riscv_data,
    output logic [ADDR_WIDTH-1:0]     riscv_address,
    output logic [WM_BANKS-1:0]       wm_enable_write,
    output logic [WM_BANKS-1:0]       bm_enable_write,
    output logic [DATA_WIDTH-1:0]     data_in_from_previous,
    output logic                      ifm_enable_write_previous,
    output logic [IFM_ADDR_WIDTH-1:0] ifm_address_write_previous,
    output logic                      start_from_previous,
    input  logic                      end_to_previous,
    output logic                      busy,
    output logic                      done
);

    state_e state_q, state_d;
    logic   armed_q, armed_d;

    logic   loading;
    logic   seq_clear;
    logic   wb_accept;
    logic   wb_sel;
    logic   wb_last;
    logic   ifm_accept;
    logic   ifm_last;
    logic [0:0] ifm_we_a;
    logic [0:0] ifm_we_b;

    assign loading = (state_q == LOAD_WM) ||
                     (state_q == LOAD_BM) ||
                     (state_q == LOAD_IFM);

    assign wb_sel     = (state_q == LOAD_BM);
    assign wb_accept  = in_if.in_valid &&
                        ((state_q == LOAD_WM) || wb_sel);
    assign ifm_accept = in_if.in_valid &&
                        (state_q == LOAD_IFM);

    always_comb begin
        state_d   = state_q;
        seq_clear = 1'b0;
        // end_to_previous may still be high from the last run
        armed_d   = (state_q == WAIT_END);
        unique case (state_q)
            IDLE: begin
                if (cfg_go) begin
                    seq_clear = 1'b1;
                    state_d   = cfg_skip_weights ? LOAD_IFM
                                                 : LOAD_WM;
                end
            end
            LOAD_WM: begin
                if (wb_last) state_d = LOAD_BM;
            end
            LOAD_BM: begin
                if (wb_last) state_d = LOAD_IFM;
            end
            LOAD_IFM: begin
                if (ifm_last) state_d = START;
            end
            START: begin
                state_d = WAIT_END;
            end
            WAIT_END: begin
                if (armed_q && end_to_previous) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
        end
    end

    convb_bank_writer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BANKS      (WM_BANKS),
        .DEPTH_A    (WM_DEPTH),
        .DEPTH_B    (BM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wb (
        .clk     (clk),
        .reset   (reset),
        .clear   (seq_clear),
        .accept  (wb_accept),
        .sel     (wb_sel),
        .wdata   (in_if.in_data),
        .last    (wb_last),
        .wr_en_a (wm_enable_write),
        .wr_en_b (bm_enable_write),
        .wr_addr (riscv_address),
        .wr_data (riscv_data)
    );

    convb_bank_writer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BANKS      (1),
        .DEPTH_A    (IFM_WORDS),
        .DEPTH_B    (IFM_WORDS),
        .ADDR_WIDTH (IFM_ADDR_WIDTH)
    ) u_ifm (
        .clk     (clk),
        .reset   (reset),
        .clear   (seq_clear),
        .accept  (ifm_accept),
        .sel     (1'b0),
        .wdata   (in_if.in_data),
        .last    (ifm_last),
        .wr_en_a (ifm_we_a),
        .wr_en_b (ifm_we_b),
        .wr_addr (ifm_address_write_previous),
        .wr_data (data_in_from_previous)
    );

    assign ifm_enable_write_previous = ifm_we_a[0] | ifm_we_b[0];

    assign in_if.in_ready      = loading;
    assign start_from_previous = (state_q == START);
    assign busy                = (state_q != IDLE);
    assign done                = (state_q == DONE);

endmodule

// File: tb/tb_convb_load_sequencer.sv
// Directed bench: cycle table for short corner cases plus
// full-stream runs checked against an address-order model.
module tb_convb_load_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_go = 1'b0;
    logic        cfg_skip_weights = 1'b0;
    logic        end_to_previous = 1'b0;
    logic [31:0] riscv_data;
    logic [14:0] riscv_address;
    logic [2:0]  wm_enable_write;
    logic [2:0]  bm_enable_write;
    logic [31:0] data_in_from_previous;
    logic        ifm_enable_write_previous;
    logic [7:0]  ifm_address_write_previous;
    logic        start_from_previous;
    logic        busy;
    logic        done;

    convb_load_sequencer_if #(.DATA_WIDTH(32)) in_if ();

    convb_load_sequencer dut (
        .clk                        (clk),
        .reset                      (reset),
        .cfg_go                     (cfg_go),
        .cfg_skip_weights           (cfg_skip_weights),
        .in_if                      (in_if),
        .riscv_data                 (riscv_data),
        .riscv_address              (riscv_address),
        .wm_enable_write            (wm_enable_write),
        .bm_enable_write            (bm_enable_write),
        .data_in_from_previous      (data_in_from_previous),
        .ifm_enable_write_previous  (ifm_enable_write_previous),
        .ifm_address_write_previous (ifm_address_write_previous),
        .start_from_previous        (start_from_previous),
        .end_to_previous            (end_to_previous),
        .busy                       (busy),
        .done                       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        go;
        logic        skip;
        logic        valid;
        logic [31:0] data;
        logic        rdy;
        logic        bsy;
        logic [2:0]  wm;
        logic        ifm;
        logic [7:0]  iaddr;
        logic [31:0] idata;
        logic [14:0] raddr;
        logic [31:0] rdata;
    } vec_t;

    vec_t        tv [14];
    int          checks = 0;
    int          passed = 0;
    int          wr_idx = 0;
    bit          mode_skip = 1'b0;
    logic [31:0] dbase = '0;

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] snap();
        return 128'({in_if.in_ready, busy, done,
                     start_from_previous,
                     wm_enable_write, bm_enable_write,
                     ifm_enable_write_previous,
                     ifm_address_write_previous,
                     data_in_from_previous,
                     riscv_address, riscv_data});
    endfunction

    task automatic exp_write(input int k,
                             output logic [2:0] w,
                             output logic [2:0] b,
                             output logic f,
                             output int a);
        w = '0; b = '0; f = 1'b0; a = 0;
        if (mode_skip) begin
            f = 1'b1; a = k;
        end else if (k < 2700) begin
            w = 3'(1 << (k / 900)); a = k % 900;
        end else if (k < 2718) begin
            b = 3'(1 << ((k - 2700) / 6)); a = (k - 2700) % 6;
        end else begin
            f = 1'b1; a = k - 2718;
        end
    endtask

    task automatic check_writes(input bit acc);
        logic [2:0]  w, b;
        logic        f;
        int          a;
        logic [14:0] got_a;
        logic [31:0] got_d;
        if (acc) begin
            exp_write(wr_idx, w, b, f, a);
            got_a = f ? 15'(ifm_address_write_previous)
                      : riscv_address;
            got_d = f ? data_in_from_previous : riscv_data;
            chk($sformatf("write[%0d]", wr_idx),
                128'({wm_enable_write, bm_enable_write,
                      ifm_enable_write_previous, got_a, got_d}),
                128'({w, b, f, 15'(a), dbase + 32'(wr_idx)}));
            wr_idx++;
        end else begin
            chk("gap_enables",
                128'({wm_enable_write, bm_enable_write,
                      ifm_enable_write_previous}), 128'(0));
        end
    endtask

    task automatic cycle(output bit acc);
        @(negedge clk);
        acc = in_if.in_valid && in_if.in_ready;
        @(posedge clk);
        #1;
        check_writes(acc);
    endtask

    task automatic kick(input bit skip);
        bit acc;
        mode_skip = skip;
        wr_idx = 0;
        in_if.in_valid = 1'b0;
        cfg_go = 1'b1;
        cfg_skip_weights = skip;
        cycle(acc);
        cfg_go = 1'b0;
        cfg_skip_weights = 1'b0;
        chk("kick", 128'({busy, in_if.in_ready}), 128'(2'b11));
    endtask

    task automatic run_stream(input int total, input bit gaps,
                              input int go_at, input int guard);
        int sent = 0;
        int n = 0;
        bit acc;
        while (sent < total && n < guard) begin
            in_if.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_if.in_data = dbase + 32'(sent);
            cfg_go = (sent == go_at);
            n++;
            cycle(acc);
            if (acc) sent++;
        end
        in_if.in_valid = 1'b0;
        cfg_go = 1'b0;
        chk("stream_count", 128'(sent), 128'(total));
    endtask

    task automatic finish_seq(input bit end_high);
        logic [2:0] exp_hi [4];
        bit acc;
        int dn = 0;
        int bad = 0;
        exp_hi[0] = 3'b001;
        exp_hi[1] = 3'b001;
        exp_hi[2] = 3'b011;
        exp_hi[3] = 3'b000;
        chk("start_pulse",
            128'({start_from_previous, busy}), 128'(2'b11));
        if (end_high) begin
            for (int i = 0; i < 4; i++) begin
                cycle(acc);
                if (done) dn++;
                chk($sformatf("wait_end_hi[%0d]", i),
                    128'({start_from_previous, done, busy}),
                    128'(exp_hi[i]));
            end
        end else begin
            for (int i = 0; i < 30; i++) begin
                cycle(acc);
                if (done) dn++;
                if (!busy || done || start_from_previous) bad++;
            end
            chk("hold_busy", 128'(bad), 128'(0));
            end_to_previous = 1'b1;
            cycle(acc);
            if (done) dn++;
            chk("done_after_end", 128'({done, busy}), 128'(2'b11));
            end_to_previous = 1'b0;
            cycle(acc);
            if (done) dn++;
            chk("back_idle", 128'({done, busy}), 128'(2'b00));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            if (done) dn++;
        end
        chk("done_count", 128'({busy, 32'(dn)}), 128'({1'b0, 32'd1}));
    endtask

    initial begin
        bit acc;
        in_if.in_valid = 1'b0;
        in_if.in_data = '0;

        //           rst go sk v  data        rdy bsy wm  ifm ia  idata       ra  rdata
        tv[0]  = '{1, 0, 0, 1, 32'hA1,      0, 0, 0, 0, 0, 32'h0,     0, 32'h0};
        tv[1]  = '{1, 1, 1, 1, 32'hA2,      1, 1, 0, 0, 0, 32'h0,     0, 32'h0};
        tv[2]  = '{1, 0, 0, 0, 32'hA3,      1, 1, 0, 0, 0, 32'h0,     0, 32'h0};
        tv[3]  = '{1, 0, 0, 1, 32'hB3,      1, 1, 0, 1, 0, 32'hB3,    0, 32'h0};
        tv[4]  = '{1, 1, 0, 1, 32'hB4,      1, 1, 0, 1, 1, 32'hB4,    0, 32'h0};
        tv[5]  = '{1, 0, 0, 0, 32'hB5,      1, 1, 0, 0, 1, 32'hB4,    0, 32'h0};
        tv[6]  = '{1, 0, 0, 1, 32'hB6,      1, 1, 0, 1, 2, 32'hB6,    0, 32'h0};
        tv[7]  = '{0, 0, 0, 1, 32'hB7,      0, 0, 0, 0, 0, 32'h0,     0, 32'h0};
        tv[8]  = '{1, 0, 0, 1, 32'hB8,      0, 0, 0, 0, 0, 32'h0,     0, 32'h0};
        tv[9]  = '{1, 1, 0, 0, 32'hC9,      1, 1, 0, 0, 0, 32'h0,     0, 32'h0};
        tv[10] = '{1, 0, 0, 1, 32'hC10,     1, 1, 1, 0, 0, 32'h0,     0, 32'hC10};
        tv[11] = '{1, 0, 0, 1, 32'hC11,     1, 1, 1, 0, 0, 32'h0,     1, 32'hC11};
        tv[12] = '{1, 0, 0, 0, 32'hC12,     1, 1, 0, 0, 0, 32'h0,     1, 32'hC11};
        tv[13] = '{0, 1, 0, 1, 32'hC13,     0, 0, 0, 0, 0, 32'h0,     0, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", snap(), 128'(0));
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            reset = tv[i].rst;
            cfg_go = tv[i].go;
            cfg_skip_weights = tv[i].skip;
            in_if.in_valid = tv[i].valid;
            in_if.in_data = tv[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("vec[%0d]", i), snap(),
                128'({tv[i].rdy, tv[i].bsy, 1'b0, 1'b0,
                      tv[i].wm, 3'b000, tv[i].ifm, tv[i].iaddr,
                      tv[i].idata, tv[i].raddr, tv[i].rdata}));
        end

        cfg_go = 1'b0;
        cfg_skip_weights = 1'b0;
        in_if.in_valid = 1'b0;
        reset = 1'b1;
        cycle(acc);

        dbase = 32'h1000_0000;
        end_to_previous = 1'b0;
        kick(1'b0);
        run_stream(2914, 1'b0, -1, 4000);
        finish_seq(1'b0);

        dbase = 32'h2000_0000;
        end_to_previous = 1'b1;
        kick(1'b0);
        run_stream(2914, 1'b1, -1, 20000);
        finish_seq(1'b1);

        dbase = 32'h3000_0000;
        kick(1'b1);
        run_stream(196, 1'b1, -1, 2000);
        finish_seq(1'b1);

        dbase = 32'h4000_0000;
        end_to_previous = 1'b0;
        kick(1'b0);
        run_stream(1351, 1'b0, -1, 3000);
        chk("pre_reset", 128'({wm_enable_write, riscv_address}),
            128'({3'b010, 15'd450}));
        reset = 1'b0;
        #1;
        chk("async_reset", snap(), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(acc);
        chk("after_release", snap(), 128'(0));

        dbase = 32'h5000_0000;
        kick(1'b0);
        run_stream(2914, 1'b0, 2768, 4000);
        finish_seq(1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
